// File: rtl/lc3_mem_arbiter_pkg.sv
// Shared types and constants for the LC-3 memory arbiter.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int unsigned DEFAULT_AW = 16;
    localparam int unsigned DEFAULT_DW = 16;

    // Wait-state counter is sized for the largest legal WAIT_CYCLES.
    localparam int unsigned WAIT_MAX = 15;
    localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// Requester, SRAM and status signals of the memory arbiter.
// slave: the arbiter side; master: the system side (requesters and SRAM).
interface lc3_mem_arbiter_if
    import lc3_mem_pkg::*;
#(
    parameter int unsigned AW = DEFAULT_AW,
    parameter int unsigned DW = DEFAULT_DW
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ready;
    logic [DW-1:0] dma_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          grant;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_ready, cpu_rdata, dma_ready, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, grant
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_ready, cpu_rdata, dma_ready, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, grant
    );

endinterface

// File: rtl/lc3_mem_arbiter_rr_arb2.sv
// Two-input round-robin picker: a lone requester wins, a tie goes to the
// port that did not win last time.
module lc3_rr_arb2
    import lc3_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       win,
    output logic       any
);

    // Pick the winner from the request pair and the previous owner.
    always_comb begin
        any = |req;
        win = PORT_CPU;
        if (&req) begin
            win = ~last_grant;
        end else if (req[PORT_DMA]) begin
            win = PORT_DMA;
        end
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares one synchronous SRAM between the CPU control path and the DMA
// engine. Each access holds the SRAM enabled for WAIT_CYCLES cycles and
// then pulses the owner's ready for one cycle.
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int unsigned AW          = DEFAULT_AW,
    parameter int unsigned DW          = DEFAULT_DW,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input logic              clk,
    input logic              reset,
    lc3_mem_arbiter_if.slave bus
);

    localparam cnt_t CntInit = cnt_t'(WAIT_CYCLES - 1);

    state_e        state_q, state_d;
    cnt_t          cnt_q, cnt_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;

    logic arb_win;
    logic arb_any;

    lc3_rr_arb2 u_arb (
        .req        ({bus.dma_req, bus.cpu_req}),
        .last_grant (last_grant_q),
        .win        (arb_win),
        .any        (arb_any)
    );

    // Next-state: grant in IDLE, count wait states in ACCESS, retire in DONE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d  = arb_win;
                    mem_en_d = 1'b1;
                    cnt_d    = CntInit;
                    state_d  = ACCESS;
                    if (arb_win == PORT_DMA) begin
                        mem_we_d    = bus.dma_we;
                        mem_addr_d  = bus.dma_addr;
                        mem_wdata_d = bus.dma_wdata;
                    end else begin
                        mem_we_d    = bus.cpu_we;
                        mem_addr_d  = bus.cpu_addr;
                        mem_wdata_d = bus.cpu_wdata;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d  = DONE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    // SRAM data is valid by the last access cycle.
                    if (!mem_we_q) begin
                        if (grant_q == PORT_DMA) begin
                            dma_rdata_d = bus.mem_rdata;
                        end else begin
                            cpu_rdata_d = bus.mem_rdata;
                        end
                    end
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            grant_q      <= PORT_CPU;
            last_grant_q <= PORT_DMA;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign bus.cpu_ready = (state_q == DONE) && (grant_q == PORT_CPU);
    assign bus.dma_ready = (state_q == DONE) && (grant_q == PORT_DMA);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.grant     = grant_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: directed cases with literal
// expectations, then randomized traffic against a timeline model.
module tb_lc3_mem_arbiter;

    localparam int W = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    lc3_mem_arbiter_if #(.AW(16), .DW(16)) bus ();

    lc3_mem_arbiter #(
        .AW          (16),
        .DW          (16),
        .WAIT_CYCLES (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Requester drive values, index 0 = CPU, 1 = DMA.
    logic [1:0]  t_req = '0;
    logic [1:0]  t_we  = '0;
    logic [15:0] t_addr [2];
    logic [15:0] t_wdata[2];

    assign bus.cpu_req   = t_req[0];
    assign bus.cpu_we    = t_we[0];
    assign bus.cpu_addr  = t_addr[0];
    assign bus.cpu_wdata = t_wdata[0];
    assign bus.dma_req   = t_req[1];
    assign bus.dma_we    = t_we[1];
    assign bus.dma_addr  = t_addr[1];
    assign bus.dma_wdata = t_wdata[1];

    // SRAM environment; initial pattern puts 16'h1234 at 16'h3000.
    logic [15:0] sram[65536];
    logic        sram_init = 1'b0;

    assign bus.mem_rdata = sram[bus.mem_addr];

    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 65536; i++) sram[i] <= 16'(i) ^ 16'h2234;
            sram_init <= 1'b1;
        end else if (bus.mem_en && bus.mem_we) begin
            sram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_pos counts cycles since the grant edge
    // (0 = no access in progress, 1..W = SRAM held, W+1 = ready cycle).
    logic [15:0] ref_mem[65536];
    logic        ref_init = 1'b0;
    int          m_pos    = 0;
    logic        m_grant  = 1'b0;
    logic        m_last   = 1'b1;
    logic        m_we     = 1'b0;
    logic [15:0] m_addr   = '0;
    logic [15:0] m_wdata  = '0;
    logic [15:0] m_rdata[2] = '{16'h0, 16'h0};

    function automatic logic pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) return ~last;
        return req[1];
    endfunction

    always @(posedge clk) begin
        if (!ref_init) begin
            for (int i = 0; i < 65536; i++) ref_mem[i] <= 16'(i) ^ 16'h2234;
            ref_init <= 1'b1;
        end else if (m_pos >= 1 && m_pos <= W && m_we) begin
            ref_mem[m_addr] <= m_wdata;
        end

        if (reset) begin
            m_pos      <= 0;
            m_grant    <= 1'b0;
            m_last     <= 1'b1;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_rdata[0] <= '0;
            m_rdata[1] <= '0;
        end else if (m_pos == 0) begin
            if (t_req != 2'b00) begin
                m_grant <= pick(t_req, m_last);
                m_we    <= t_we[pick(t_req, m_last)];
                m_addr  <= t_addr[pick(t_req, m_last)];
                m_wdata <= t_wdata[pick(t_req, m_last)];
                m_pos   <= 1;
            end
        end else if (m_pos <= W) begin
            if (m_pos == W && !m_we) m_rdata[m_grant] <= ref_mem[m_addr];
            m_pos <= m_pos + 1;
        end else begin
            m_last <= m_grant;
            m_pos  <= 0;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (ref_init) begin
            chk("m_busy",      bus.busy,      m_pos != 0);
            chk("m_mem_en",    bus.mem_en,    m_pos >= 1 && m_pos <= W);
            chk("m_mem_we",    bus.mem_we,    m_pos >= 1 && m_pos <= W && m_we);
            chk("m_mem_addr",  bus.mem_addr,  m_addr);
            chk("m_mem_wdata", bus.mem_wdata, m_wdata);
            chk("m_grant",     bus.grant,     m_grant);
            chk("m_cpu_ready", bus.cpu_ready, m_pos == W + 1 && m_grant == 1'b0);
            chk("m_dma_ready", bus.dma_ready, m_pos == W + 1 && m_grant == 1'b1);
            chk("m_cpu_rdata", bus.cpu_rdata, m_rdata[0]);
            chk("m_dma_rdata", bus.dma_rdata, m_rdata[1]);
        end
    end

    task automatic start(input int p, input logic we, input logic [15:0] a,
                         input logic [15:0] d);
        t_req[p]   = 1'b1;
        t_we[p]    = we;
        t_addr[p]  = a;
        t_wdata[p] = d;
    endtask

    task automatic new_access(input int p);
        start(p, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom));
    endtask

    // Protocol-following requester: holds until ready, sometimes drops early.
    task automatic agent(input int p);
        logic rdy;
        rdy = (p == 0) ? bus.cpu_ready : bus.dma_ready;
        if (t_req[p] && rdy) begin
            if ($urandom_range(0, 1) == 1) new_access(p);
            else t_req[p] = 1'b0;
        end else if (t_req[p] && $urandom_range(0, 15) == 0) begin
            t_req[p] = 1'b0;
        end else if (!t_req[p] && $urandom_range(0, 2) == 0) begin
            new_access(p);
        end
    endtask

    initial begin
        t_addr[0]  = '0;
        t_addr[1]  = '0;
        t_wdata[0] = '0;
        t_wdata[1] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy",      bus.busy,      1'b0);
        chk("rst_mem_en",    bus.mem_en,    1'b0);
        chk("rst_mem_addr",  bus.mem_addr,  16'h0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 16'h0);
        chk("rst_grant",     bus.grant,     1'b0);

        // CPU read of 16'h3000.
        start(0, 1'b0, 16'h3000, 16'h0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("t1_mem_en", bus.mem_en, k <= 3);
            chk("t1_cpu_ready", bus.cpu_ready, k == 4);
            if (k <= 3) begin
                chk("t1_mem_addr", bus.mem_addr, 16'h3000);
                chk("t1_mem_we",   bus.mem_we,   1'b0);
            end
            if (k == 4) begin
                chk("t1_cpu_rdata", bus.cpu_rdata, 16'h1234);
                chk("t1_dma_rdata", bus.dma_rdata, 16'h0);
                t_req[0] = 1'b0;
            end
            if (k == 5) chk("t1_busy", bus.busy, 1'b0);
        end

        // CPU write of 16'hBEEF to 16'h4001.
        start(0, 1'b1, 16'h4001, 16'hBEEF);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t2_cpu_ready", bus.cpu_ready, k == 4);
            if (k <= 3) begin
                chk("t2_mem_we",    bus.mem_we,    1'b1);
                chk("t2_mem_wdata", bus.mem_wdata, 16'hBEEF);
            end
            if (k == 4) begin
                chk("t2_cpu_rdata", bus.cpu_rdata, 16'h1234);
                t_req[0] = 1'b0;
            end
        end
        @(negedge clk);

        // DMA reads back what the CPU wrote.
        start(1, 1'b0, 16'h4001, 16'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t3_dma_ready", bus.dma_ready, k == 4);
            if (k == 2) chk("t3_grant", bus.grant, 1'b1);
            if (k == 4) begin
                chk("t3_dma_rdata", bus.dma_rdata, 16'hBEEF);
                chk("t3_cpu_rdata", bus.cpu_rdata, 16'h1234);
                t_req[1] = 1'b0;
            end
        end
        @(negedge clk);

        // DMA alone, CPU joins mid-access and is served next.
        start(1, 1'b0, 16'h3000, 16'h0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("t4_dma_ready", bus.dma_ready, k == 4);
            chk("t4_cpu_ready", bus.cpu_ready, k == 9);
            if (k == 2) start(0, 1'b0, 16'h4001, 16'h0);
            if (k == 4) begin
                chk("t4_dma_rdata", bus.dma_rdata, 16'h1234);
                t_req[1] = 1'b0;
            end
            if (k == 7) chk("t4_grant", bus.grant, 1'b0);
            if (k == 9) begin
                chk("t4_cpu_rdata", bus.cpu_rdata, 16'hBEEF);
                t_req[0] = 1'b0;
            end
            if (k == 10) chk("t4_busy", bus.busy, 1'b0);
        end

        // CPU drops req during a write; write and ready still happen.
        start(0, 1'b1, 16'h0010, 16'hCAFE);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("t5_cpu_ready", bus.cpu_ready, k == 4);
            if (k == 2) t_req[0] = 1'b0;
            if (k == 3) begin
                chk("t5_mem_we",    bus.mem_we,    1'b1);
                chk("t5_mem_wdata", bus.mem_wdata, 16'hCAFE);
            end
            if (k == 6) chk("t5_busy", bus.busy, 1'b0);
        end
        start(1, 1'b0, 16'h0010, 16'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) begin
                chk("t5_readback", bus.dma_rdata, 16'hCAFE);
                t_req[1] = 1'b0;
            end
        end
        @(negedge clk);

        // Both requesting from reset: strict alternation starting with CPU.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_rst_rdata", bus.dma_rdata, 16'h0);
        start(0, 1'b0, 16'h3000, 16'h0);
        start(1, 1'b0, 16'h4001, 16'h0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("t6_cpu_ready", bus.cpu_ready, k == 4 || k == 14);
            chk("t6_dma_ready", bus.dma_ready, k == 9 || k == 19);
            if (k % 5 == 2) chk("t6_grant", bus.grant, (k / 5) % 2);
            if (k == 19) t_req = 2'b00;
            if (k == 20) chk("t6_busy", bus.busy, 1'b0);
        end

        // Reset during an access: no ready, back to IDLE, rdata cleared.
        start(0, 1'b1, 16'h0020, 16'h1111);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 2) begin
                reset    = 1'b1;
                t_req[0] = 1'b0;
            end
            if (k == 3) begin
                chk("t7_busy",      bus.busy,      1'b0);
                chk("t7_mem_en",    bus.mem_en,    1'b0);
                chk("t7_cpu_rdata", bus.cpu_rdata, 16'h0);
                reset = 1'b0;
            end
            if (k >= 3) begin
                chk("t7_cpu_ready", bus.cpu_ready, 1'b0);
                chk("t7_dma_ready", bus.dma_ready, 1'b0);
            end
        end

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 299) == 0);
            agent(0);
            agent(1);
        end
        reset = 1'b0;
        t_req = 2'b00;
        repeat (W + 4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Sequences every memory access in the LC-3 system and shares one synchronous SRAM between two requesters: the CPU control path (MAR/MDR, MIO_EN, R.W) and a DMA/console engine.
- Generates the memory-ready pulse R that the control FSM waits on in its memory states (fetch, load, store, indirect).
- Fixed wait-state count; two-way round-robin arbitration between requesters.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- WAIT_CYCLES, 3, cycles the SRAM is held enabled per access; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request (MIO_EN); level, held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read (R.W)
- cpu_addr  in  AW  MAR value
- cpu_wdata  in  DW  MDR value for writes
- cpu_ready  out  1  one-cycle completion pulse (R to control FSM)
- cpu_rdata  out  DW  read data; valid while cpu_ready=1 and held afterwards
- dma_req  in  1  DMA access request
- dma_we  in  1  DMA write enable
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_ready  out  1  one-cycle completion pulse
- dma_rdata  out  DW  DMA read data, same rules as cpu_rdata
- mem_en  out  1  SRAM enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  AW  SRAM address
- mem_wdata  out  DW  SRAM write data
- mem_rdata  in  DW  SRAM read data, valid by the last ACCESS cycle
- busy  out  1  1 whenever state != IDLE
- grant  out  1  owner of current access: 0 = CPU, 1 = DMA

Behaviour:
- Reset values: state=IDLE; all ready, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, cpu_rdata, dma_rdata = 0; grant=0; last_grant=1, so the CPU wins the first tie.
- FSM states:
  - IDLE: at an edge where any req=1, select a winner, latch addr/wdata/we into the mem_* registers, set grant, mem_en=1, mem_we=we, cnt=WAIT_CYCLES-1, go to ACCESS. If no req, stay.
  - ACCESS: mem_* outputs are held stable. At each edge: if cnt!=0, decrement cnt. If cnt==0, go to DONE, drop mem_en/mem_we, and for a read capture mem_rdata into the granted port's rdata.
  - DONE: the granted port's ready=1 for exactly this cycle; last_grant<=grant; go to IDLE.
- Latency: req high in cycle 0 gives ACCESS in cycles 1..WAIT_CYCLES and ready in cycle WAIT_CYCLES+1. Back-to-back access period is WAIT_CYCLES+2 cycles.
- Arbitration: evaluated only in IDLE.
  - Single requester wins.
  - Both requesting: the port != last_grant wins (strict alternation).
- Requester protocol:
  - Hold req, addr, we and wdata stable until ready.
  - Req still high in the IDLE cycle after ready is a new access.
  - Inputs are sampled only at the IDLE grant edge; later changes are ignored.
- Req dropped mid-access: the access completes, a write is still performed, and ready still pulses.
- Writes: the port's rdata is not modified. Reads: the other port's rdata is never modified.
- Reset mid-access: next cycle IDLE, mem_en=0, no ready pulse, rdata=0. An aborted write may be partial and is not re-issued.
- Only one ready is ever high in a cycle. Ready is never high while state=IDLE or ACCESS.

Decomposition:
- Package lc3_mem_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - port IDs PORT_CPU=0, PORT_DMA=1
  - default AW/DW
  - cnt width derived from the WAIT_CYCLES maximum (4 bits)
- Optional sub-module lc3_rr_arb2: two-input round-robin picker; inputs req[1:0], last_grant; outputs win, any. Purely combinational. All sequencing stays in the top module.

Test Plan:
- CPU read, WAIT_CYCLES=3, mem_rdata=16'h1234, addr 16'h3000, req at cycle 0 -> mem_en high cycles 1-3 with mem_addr=16'h3000, mem_we=0; cpu_ready high only in cycle 4; cpu_rdata=16'h1234; dma_rdata unchanged.
- CPU write 16'hBEEF to 16'h4001 -> mem_we=1 and mem_wdata=16'hBEEF for cycles 1-3; cpu_ready in cycle 4; cpu_rdata unchanged.
- Both req held high from reset -> grants alternate CPU, DMA, CPU, DMA; ready pulses at cycles 4, 9, 14, 19.
- DMA req alone, then CPU req raised in cycle 2 -> DMA access completes (dma_ready cycle 4); CPU granted at cycle 5; cpu_ready cycle 9.
- CPU req dropped at cycle 2 of a write -> write still performed through cycle 3; cpu_ready still pulses in cycle 4; next IDLE stays idle.
- reset asserted in cycle 2 of an access -> cycle 3: state IDLE, mem_en=0, busy=0, no ready pulse in cycles 3-6.
